// File: rtl/serial_cmp_pkg.sv
// Shared constants for the serial magnitude comparator controller.
// The state encodings are fixed because other blocks already decode them.
package serial_cmp_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter width that can hold every value from 0 to width
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/comparator_1_bit.sv
// Purely combinational single-bit magnitude comparator.
// This is the shared bit datapath that the serial controller steps through.
module comparator_1_bit (
  input  logic a,
  input  logic b,
  output logic a_eq_b,
  output logic a_lt_b,
  output logic a_gt_b
);

  assign a_eq_b = ~(a ^ b);
  assign a_lt_b = ~a & b;
  assign a_gt_b = a & ~b;

endmodule

// File: rtl/serial_mag_comparator_ctrl.sv
// Serial MSB-first magnitude compare of two unsigned operands using one 1-bit comparator.
// The compare stops at the first differing bit and reports it with a one-cycle done pulse.
module serial_mag_comparator_ctrl
  import serial_cmp_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic          busy,
  output logic          done,
  output logic          a_eq_b,
  output logic          a_lt_b,
  output logic          a_gt_b,
  output logic [CW-1:0] diff_idx
);

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             bit_eq;
  logic             bit_lt;
  logic             bit_gt;

  comparator_1_bit u_bit (
    .a      (sa[WIDTH-1]),
    .b      (sb[WIDTH-1]),
    .a_eq_b (bit_eq),
    .a_lt_b (bit_lt),
    .a_gt_b (bit_gt)
  );

  // cnt tracks the original bit position of the bit currently in the MSB slot
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sa       <= '0;
      sb       <= '0;
      cnt      <= '0;
      a_eq_b   <= 1'b0;
      a_lt_b   <= 1'b0;
      a_gt_b   <= 1'b0;
      diff_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            cnt   <= CW'(WIDTH - 1);
            state <= S_CMP;
          end
        end
        S_CMP: begin
          if (!bit_eq) begin
            a_eq_b   <= 1'b0;
            a_lt_b   <= bit_lt;
            a_gt_b   <= bit_gt;
            diff_idx <= cnt;
            state    <= S_DONE;
          end else if (cnt == '0) begin
            a_eq_b   <= 1'b1;
            a_lt_b   <= 1'b0;
            a_gt_b   <= 1'b0;
            diff_idx <= '0;
            state    <= S_DONE;
          end else begin
            sa  <= sa << 1;
            sb  <= sb << 1;
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_mag_comparator_ctrl.sv
// Directed bench for serial_mag_comparator_ctrl at WIDTH=8 and WIDTH=1.
// Expected latencies and flags are hand-computed from the operand bit patterns.
module tb_serial_mag_comparator_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8, eq8, lt8, gt8;
  logic [3:0] idx8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       busy1, done1, eq1, lt1, gt1;
  logic [0:0] idx1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_mag_comparator_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .a_eq_b(eq8), .a_lt_b(lt8), .a_gt_b(gt8),
    .diff_idx(idx8)
  );

  serial_mag_comparator_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .a_eq_b(eq1), .a_lt_b(lt1), .a_gt_b(gt1),
    .diff_idx(idx1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one compare and follow it until busy drops (bounded to 20 cycles)
  task automatic do_cmp(input string tag, input bit wide, input logic [7:0] av,
                        input logic [7:0] bv, input bit hold, input int exp_busy,
                        input int exp_done_at, input bit eeq, input bit elt,
                        input bit egt, input int eidx);
    int  n, busy_cnt, done_cnt, done_at;
    logic ob, od;
    if (wide) begin
      a8 = av; b8 = bv; start8 = 1'b1;
    end else begin
      a1 = av[0:0]; b1 = bv[0:0]; start1 = 1'b1;
    end
    step();
    if (hold) begin
      a8 = 8'hFF; b8 = 8'h00;
    end else begin
      start8 = 1'b0; start1 = 1'b0;
    end
    n = 1; busy_cnt = 0; done_cnt = 0; done_at = 0;
    while (n <= 20) begin
      ob = wide ? busy8 : busy1;
      od = wide ? done8 : done1;
      if (ob) busy_cnt++;
      if (od) begin
        done_cnt++;
        done_at = n;
        start8 = 1'b0; start1 = 1'b0;
        check({tag, ".eq"},  32'(wide ? eq8 : eq1), 32'(eeq));
        check({tag, ".lt"},  32'(wide ? lt8 : lt1), 32'(elt));
        check({tag, ".gt"},  32'(wide ? gt8 : gt1), 32'(egt));
        check({tag, ".idx"}, wide ? 32'(idx8) : 32'(idx1), 32'(eidx));
      end
      if (!ob) break;
      step();
      n++;
    end
    start8 = 1'b0; start1 = 1'b0;
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, ".done_cycle"},  32'(done_at),  32'(exp_done_at));
    check({tag, ".done_count"},  32'(done_cnt), 32'd1);
  endtask

  initial begin
    int dcount;
    step();
    step();
    rst = 1'b0;
    check("rst.busy8", 32'(busy8), 32'd0);
    check("rst.done8", 32'(done8), 32'd0);
    check("rst.flags8", {29'd0, eq8, lt8, gt8}, 32'd0);
    check("rst.idx8", 32'(idx8), 32'd0);
    check("rst.flags1", {29'd0, eq1, lt1, gt1}, 32'd0);
    step();
    step();
    check("idle.flags8", {29'd0, eq8, lt8, gt8}, 32'd0);

    do_cmp("eq_a5", 1'b1, 8'hA5, 8'hA5, 1'b0, 9, 9, 1'b1, 1'b0, 1'b0, 0);
    // Starts in the IDLE cycle right after the previous done
    do_cmp("gt_80", 1'b1, 8'h80, 8'h7F, 1'b0, 2, 2, 1'b0, 1'b0, 1'b1, 7);
    do_cmp("lt_12", 1'b1, 8'h12, 8'h13, 1'b0, 9, 9, 1'b0, 1'b1, 1'b0, 0);

    step();
    step();
    step();
    check("hold.flags", {29'd0, eq8, lt8, gt8}, 32'b010);
    check("hold.idx", 32'(idx8), 32'd0);
    check("hold.done", 32'(done8), 32'd0);

    do_cmp("busy_start", 1'b1, 8'h01, 8'h02, 1'b1, 8, 8, 1'b0, 1'b1, 1'b0, 1);

    a8 = 8'hA5; b8 = 8'hA5; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    check("midrst.busy_before", 32'(busy8), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst.busy", 32'(busy8), 32'd0);
    check("midrst.done", 32'(done8), 32'd0);
    check("midrst.flags", {29'd0, eq8, lt8, gt8}, 32'd0);
    check("midrst.idx", 32'(idx8), 32'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8) dcount++;
      step();
    end
    check("midrst.no_done", 32'(dcount), 32'd0);
    do_cmp("after_rst", 1'b1, 8'h80, 8'h7F, 1'b0, 2, 2, 1'b0, 1'b0, 1'b1, 7);

    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1; rst = 1'b1;
    step();
    start8 = 1'b0; rst = 1'b0;
    check("rst_start.busy", 32'(busy8), 32'd0);
    check("rst_start.flags", {29'd0, eq8, lt8, gt8}, 32'd0);
    step();
    check("rst_start.busy_later", 32'(busy8), 32'd0);
    check("rst_start.done_later", 32'(done8), 32'd0);

    do_cmp("w1_00", 1'b0, 8'h00, 8'h00, 1'b0, 2, 2, 1'b1, 1'b0, 1'b0, 0);
    do_cmp("w1_01", 1'b0, 8'h00, 8'h01, 1'b0, 2, 2, 1'b0, 1'b1, 1'b0, 0);
    do_cmp("w1_10", 1'b0, 8'h01, 8'h00, 1'b0, 2, 2, 1'b0, 1'b0, 1'b1, 0);
    do_cmp("w1_11", 1'b0, 8'h01, 8'h01, 1'b0, 2, 2, 1'b1, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
